cache_fill_fsm: RTL and testbench

Miss-handling responder for the pipelined CPU's instruction and data caches. It accepts a cache-miss request from the pipeline and issues sequential word reads to the multi-cycle, pipelined main memory. It streams the returned words into the cache data array and writes the tag when the block is complete. While it is active it holds the pipeline stalled through fsm_busy. One instance sits beside each cache (I-cache, D-cache); an external arbiter, outside this block, shares main memory between them.

---
 rtl/cache_fill_fsm.sv | 97 +++++++++
 tb/tb_cache_fill_fsm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss fill: on a miss, streams BLOCK_WORDS sequential reads to memory and installs the returned words.
// Stall asserts in the miss cycle; one request per cycle, words counted so any memory latency >= 1 works.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int IDX_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             miss_detected,
    input  logic [15:0]      miss_address,
    input  logic             memory_data_valid,
    input  logic [15:0]      memory_data,
    output logic             fsm_busy,
    output logic             mem_read,
    output logic [15:0]      memory_address,
    output logic             write_data_array,
    output logic [IDX_W-1:0] data_word_idx,
    output logic             write_tag_array,
    output logic             fill_done
);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    // Block-aligned base: clears log2(2*BLOCK_WORDS) low byte-address bits.
    localparam logic [15:0]    ALIGN_MASK = ~(16'(2 * BLOCK_WORDS) - 16'd1);
    localparam logic [IDX_W:0] REQ_END    = (IDX_W + 1)'(BLOCK_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    state_t           state;
    logic [15:0]      base_addr;
    logic [IDX_W:0]   req_cnt;
    logic [IDX_W-1:0] rcv_cnt;

    logic             in_fill;
    logic             req_pending;
    logic             last_word;
    logic [IDX_W-1:0] req_slot;
    logic [15:0]      req_offset;

    // The returned word goes straight into the data array; this block only sequences it.
    logic             unused_memory_data;
    assign unused_memory_data = ^memory_data;

    assign in_fill     = (state == FILL);
    assign req_pending = (req_cnt < REQ_END);
    assign last_word   = in_fill && memory_data_valid && (rcv_cnt == LAST_IDX);

    // After the final request the address parks on the last word of the block.
    assign req_slot    = req_pending ? req_cnt[IDX_W-1:0] : LAST_IDX;
    assign req_offset  = 16'(req_slot) << 1;

    assign fsm_busy         = in_fill || miss_detected;
    assign mem_read         = in_fill && req_pending;
    assign memory_address   = in_fill ? (base_addr + req_offset) : 16'h0000;
    assign write_data_array = in_fill && memory_data_valid;
    assign data_word_idx    = rcv_cnt;
    assign write_tag_array  = last_word;
    assign fill_done        = last_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_addr <= 16'h0000;
            req_cnt   <= '0;
            rcv_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base_addr <= miss_address & ALIGN_MASK;
                        req_cnt   <= '0;
                        rcv_cnt   <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (req_pending) begin
                        req_cnt <= req_cnt + (IDX_W + 1)'(1);
                    end
                    if (memory_data_valid) begin
                        rcv_cnt <= rcv_cnt + IDX_W'(1);
                    end
                    if (last_word) begin
                        req_cnt <= '0;
                        rcv_cnt <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomised bench for cache_fill_fsm: a request/receive queue model plus directed literal checks.
// The bench's memory answers each observed read after a random latency, optionally with gaps.
module tb_cache_fill_fsm;

    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = 16'h0;
    logic        fsm_busy, mem_read, write_data_array, write_tag_array, fill_done;
    logic [15:0] memory_address;
    logic [2:0]  data_word_idx;

    always #5 clk = ~clk;

    cache_fill_fsm #(.BLOCK_WORDS(BW), .IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
        .memory_data_valid(memory_data_valid), .memory_data(memory_data),
        .fsm_busy(fsm_busy), .mem_read(mem_read), .memory_address(memory_address),
        .write_data_array(write_data_array), .data_word_idx(data_word_idx),
        .write_tag_array(write_tag_array), .fill_done(fill_done)
    );

    int checks = 0, errors = 0, cyc = 0;

    logic        d_rst = 1'b0, d_miss = 1'b0, d_spur = 1'b0;
    logic [15:0] d_addr = 16'h0;
    int          lat_min = 4, lat_max = 4, gap_max = 0;
    bit          cmp_en = 1'b0;

    int          memq[$];
    int          last_resp = 0;

    bit          m_fill = 1'b0, m_after_rst = 1'b0;
    logic [15:0] m_reqq[$];
    logic [15:0] m_last = 16'h0;
    int          m_rcv = 0;

    int          n_req, n_tag, n_busy_low, n_wda;
    logic [15:0] first_req, last_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_counters();
        n_req = 0; n_tag = 0; n_busy_low = 0; n_wda = 0;
        first_req = 16'h0; last_req = 16'h0;
    endtask

    task automatic cycle();
        int t, g;
        logic [15:0] base;
        @(negedge clk);
        rst_n         = d_rst;
        miss_detected = d_miss;
        miss_address  = d_addr;
        memory_data   = 16'($urandom);
        memory_data_valid = 1'b0;
        if (!d_rst) memq.delete();
        else if (memq.size() > 0 && memq[0] == cyc) begin
            memory_data_valid = 1'b1;
            void'(memq.pop_front());
        end else if (d_spur && !m_fill && memq.size() == 0)
            memory_data_valid = 1'($urandom_range(0, 1));
        #1;
        if (cmp_en) begin
            if (m_fill) begin
                chk("busy_fill", fsm_busy, 1);
                chk("mem_read", mem_read, m_reqq.size() > 0);
                chk("memory_address", memory_address, (m_reqq.size() > 0) ? m_reqq[0] : m_last);
                chk("write_data_array", write_data_array, memory_data_valid);
                if (memory_data_valid) chk("data_word_idx", data_word_idx, m_rcv);
                chk("write_tag_array", write_tag_array, memory_data_valid && m_rcv == BW - 1);
                chk("fill_done", fill_done, memory_data_valid && m_rcv == BW - 1);
            end else begin
                chk("busy_idle", fsm_busy, miss_detected);
                chk("mem_read_idle", mem_read, 0);
                chk("wda_idle", write_data_array, 0);
                chk("tag_idle", write_tag_array, 0);
                chk("done_idle", fill_done, 0);
                if (m_after_rst) chk("addr_after_reset", memory_address, 0);
            end
        end
        if (mem_read === 1'b1) begin
            n_req++;
            if (n_req == 1) first_req = memory_address;
            last_req = memory_address;
            if (d_rst) begin
                t = cyc + $urandom_range(lat_min, lat_max);
                g = $urandom_range(0, gap_max);
                if (t < last_resp + 1 + g) t = last_resp + 1 + g;
                memq.push_back(t);
                last_resp = t;
            end
        end
        if (write_tag_array === 1'b1) n_tag++;
        if (write_data_array === 1'b1) n_wda++;
        if (fsm_busy !== 1'b1) n_busy_low++;
        // Reference model: a fill is a list of 8 addresses to issue and a count of words received.
        m_after_rst = !d_rst;
        if (!d_rst) begin
            m_fill = 1'b0; m_rcv = 0; m_reqq.delete();
        end else if (m_fill) begin
            if (m_reqq.size() > 0) void'(m_reqq.pop_front());
            if (memory_data_valid) begin
                if (m_rcv == BW - 1) begin m_fill = 1'b0; m_rcv = 0; end
                else m_rcv++;
            end
        end else if (miss_detected) begin
            base = miss_address & ~16'(2 * BW - 1);
            for (int k = 0; k < BW; k++) m_reqq.push_back(base + 16'(2 * k));
            m_last = base + 16'(2 * (BW - 1));
            m_fill = 1'b1; m_rcv = 0;
        end
        cyc++;
    endtask

    task automatic run_fill(input logic [15:0] a, input int max_cyc);
        int k;
        d_miss = 1'b1; d_addr = a;
        cycle();
        k = 0;
        while (m_fill && k < max_cyc) begin
            cycle();
            k++;
        end
        if (m_fill) chk("fill_timeout", k, max_cyc + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        // Reset then idle
        d_rst = 1'b0; d_miss = 1'b0;
        cycle();
        cmp_en = 1'b1;
        cycle();
        d_rst = 1'b1;
        cycle();
        chk("rst_busy", fsm_busy, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_addr", memory_address, 16'h0000);
        chk("rst_wda", write_data_array, 0);
        chk("rst_tag", write_tag_array, 0);
        chk("rst_done", fill_done, 0);

        // Basic fill, latency 4
        lat_min = 4; lat_max = 4; gap_max = 0;
        reset_counters();
        d_miss = 1'b1; d_addr = 16'h1236;
        cycle();
        chk("basic_c0_busy", fsm_busy, 1);
        for (int c = 1; c <= 13; c++) begin
            d_miss = m_fill;
            cycle();
            case (c)
                1:  begin chk("basic_c1_read", mem_read, 1); chk("basic_c1_addr", memory_address, 16'h1230); end
                5:  begin chk("basic_c5_wda", write_data_array, 1); chk("basic_c5_idx", data_word_idx, 0); end
                8:  chk("basic_c8_addr", memory_address, 16'h123E);
                9:  begin chk("basic_c9_read", mem_read, 0); chk("basic_c9_addr", memory_address, 16'h123E); end
                12: begin chk("basic_c12_tag", write_tag_array, 1); chk("basic_c12_done", fill_done, 1);
                          chk("basic_c12_idx", data_word_idx, 7); end
                13: chk("basic_c13_busy", fsm_busy, 0);
                default: ;
            endcase
        end
        chk("basic_nreq", n_req, 8);

        // Irregular valids
        lat_min = 1; lat_max = 3; gap_max = 3;
        reset_counters();
        run_fill(16'h1236, 200);
        chk("irr_ntag", n_tag, 1);
        chk("irr_nreq", n_req, 8);
        chk("irr_first", first_req, 16'h1230);
        chk("irr_last", last_req, 16'h123E);
        d_miss = 1'b0;
        cycle();

        // Back-to-back misses
        lat_min = 2; lat_max = 5; gap_max = 0;
        reset_counters();
        run_fill(16'h0040, 200);
        chk("b2b_first0", first_req, 16'h0040);
        reset_counters();
        run_fill(16'h00A2, 200);
        chk("b2b_gap", n_busy_low, 0);
        chk("b2b_first1", first_req, 16'h00A0);
        chk("b2b_last1", last_req, 16'h00AE);
        chk("b2b_ntag", n_tag, 1);
        d_miss = 1'b0;
        cycle();
        chk("b2b_drop", fsm_busy, 0);

        // Reset mid-fill
        lat_min = 1; lat_max = 3; gap_max = 2;
        d_miss = 1'b1; d_addr = 16'h1000;
        cycle();
        for (int k = 0; k < 100 && m_rcv < 3; k++) cycle();
        chk("mid_three_valids", m_rcv, 3);
        reset_counters();
        d_rst = 1'b0; d_miss = 1'b0;
        cycle();
        d_rst = 1'b1;
        cycle();
        chk("mid_busy", fsm_busy, 0);
        chk("mid_addr", memory_address, 16'h0000);
        chk("mid_read", mem_read, 0);
        chk("mid_ntag", n_tag, 0);
        reset_counters();
        run_fill(16'h2000, 200);
        chk("mid_first", first_req, 16'h2000);
        chk("mid_last", last_req, 16'h200E);
        chk("mid_wda", n_wda, 8);
        chk("mid_tag", n_tag, 1);

        // Wrap and ignore
        reset_counters();
        d_miss = 1'b1; d_addr = 16'hFFFF;
        cycle();
        for (int k = 0; k < 200 && m_fill; k++) begin
            d_miss = 1'($urandom_range(0, 1));
            d_addr = 16'($urandom);
            cycle();
        end
        chk("wrap_first", first_req, 16'hFFF0);
        chk("wrap_last", last_req, 16'hFFFE);
        chk("wrap_nreq", n_req, 8);
        chk("wrap_ntag", n_tag, 1);
        reset_counters();
        d_miss = 1'b0; d_spur = 1'b1;
        repeat (20) cycle();
        chk("idle_spur_wda", n_wda, 0);

        // Random traffic with occasional resets
        lat_min = 1; lat_max = 6; gap_max = 2;
        repeat (3000) begin
            d_rst  = ($urandom_range(0, 499) != 0);
            d_miss = m_fill ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
            d_addr = 16'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
